// File: rtl/key_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_scan_pkg
//  Description : Shared types and constants for the 4x4 key matrix scanner.
//  Revision    : 1.0
// ============================================================================
package key_scan_pkg;

    localparam int KEY_IDX_W  = 4;
    localparam int KEY_CODE_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_COMMIT = 3'd4
    } scan_state_t;

    typedef struct packed {
        logic                 press;
        logic [KEY_IDX_W-1:0] idx;
    } key_event_t;

    // Index of the least significant set bit; 0 when the vector is empty.
    function automatic logic [KEY_IDX_W-1:0] lowest_set(input logic [15:0] vec);
        logic [KEY_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = KEY_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_scan_if
//  Description : Event stream and status bundle between scanner and register slice.
//  Revision    : 1.0
// ============================================================================
interface key_scan_if #(
    parameter int FIFO_DEPTH = 8
);
    import key_scan_pkg::*;

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    logic                  key_valid;
    logic                  key_ready;
    logic [KEY_CODE_W-1:0] key_code;
    logic [15:0]           key_state;
    logic [c_cnt_w-1:0]    fifo_count;
    logic                  overflow;
    logic                  clr_overflow;
    logic                  irq;

    modport master (
        output key_valid, key_code, key_state, fifo_count, overflow, irq,
        input  key_ready, clr_overflow
    );

    modport slave (
        input  key_valid, key_code, key_state, fifo_count, overflow, irq,
        output key_ready, clr_overflow
    );

endinterface
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Synchronous show-ahead FIFO with occupancy count, full and empty.
//  Revision    : 1.0
// ============================================================================
module key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         wr_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         rd_data,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign count     = r_count;
    assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/key_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_scan_ctrl
//  Description : 4x4 key matrix scan sequencer, debouncer and event encoder.
//  Revision    : 1.0
// ============================================================================
module key_scan_ctrl
    import key_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  wire logic       ACLK,
    input  wire logic       ARESET,
    input  wire logic       enable,
    output logic      [3:0] col_n,
    input  wire logic [3:0] row_n,
    key_scan_if.master      bus
);
    localparam int             c_div_w    = $clog2(SCAN_DIV);
    localparam int             c_cnt_w    = $clog2(FIFO_DEPTH) + 1;
    localparam [c_div_w-1:0]   c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [3:0]     c_db_max   = 4'(DEBOUNCE_SCANS);

    scan_state_t        r_state;
    scan_state_t        w_next_state;
    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_col;
    logic [15:0]        r_raw;
    logic [15:0]        r_prev_raw;
    logic [15:0]        r_key_state;
    logic [3:0]         r_stable_cnt;
    logic               r_overflow;

    logic [15:0]          w_diff;
    logic [KEY_IDX_W-1:0] w_commit_idx;
    logic                 w_last_change;
    logic [3:0]           w_stable_next;
    logic                 w_push;
    key_event_t           w_event;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [c_cnt_w-1:0]   w_count;
    logic [KEY_CODE_W-1:0] w_head;

    assign w_diff        = r_raw ^ r_key_state;
    assign w_commit_idx  = lowest_set(w_diff);
    assign w_last_change = ((w_diff & (w_diff - 16'd1)) == 16'd0);
    assign w_stable_next = (r_raw != r_prev_raw)    ? 4'd0     :
                           (r_stable_cnt == c_db_max) ? c_db_max : r_stable_cnt + 4'd1;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:   if (enable) w_next_state = ST_DRIVE;
            ST_DRIVE:  if (!enable)                 w_next_state = ST_IDLE;
                       else if (r_div == c_div_last) w_next_state = ST_SAMPLE;
            ST_SAMPLE: if (!enable)            w_next_state = ST_IDLE;
                       else if (r_col == 2'd3) w_next_state = ST_EVAL;
                       else                    w_next_state = ST_DRIVE;
            ST_EVAL:   if (!enable) w_next_state = ST_IDLE;
                       else if (w_stable_next == c_db_max && w_diff != 16'd0)
                                    w_next_state = ST_COMMIT;
                       else         w_next_state = ST_DRIVE;
            ST_COMMIT: if (w_last_change) w_next_state = enable ? ST_DRIVE : ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        col_n         = 4'hF;
        w_push        = 1'b0;
        w_event.press = r_raw[w_commit_idx];
        w_event.idx   = w_commit_idx;
        if (r_state == ST_DRIVE || r_state == ST_SAMPLE) col_n = ~(4'b0001 << r_col);
        if (r_state == ST_COMMIT && w_diff != 16'd0)     w_push = 1'b1;
    end

    assign w_pop  = bus.key_valid && bus.key_ready;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_row_meta   <= 4'hF;
            r_row_sync   <= 4'hF;
            r_div        <= '0;
            r_col        <= 2'd0;
            r_raw        <= 16'd0;
            r_prev_raw   <= 16'd0;
            r_key_state  <= 16'd0;
            r_stable_cnt <= 4'd0;
            r_overflow   <= 1'b0;
        end else begin
            r_row_meta <= row_n;
            r_row_sync <= r_row_meta;

            if (r_state == ST_DRIVE && w_next_state == ST_DRIVE) r_div <= r_div + 1'b1;
            else                                                 r_div <= '0;

            if (w_next_state == ST_IDLE)  r_col <= 2'd0;
            else if (r_state == ST_SAMPLE) r_col <= r_col + 2'd1;

            if (r_state == ST_SAMPLE && enable) r_raw[{r_col, 2'b00} +: 4] <= ~r_row_sync;

            // Leaving a scan early throws away its debounce history.
            if (!enable && (r_state == ST_DRIVE || r_state == ST_SAMPLE || r_state == ST_EVAL)) begin
                r_stable_cnt <= 4'd0;
            end else if (r_state == ST_EVAL) begin
                r_stable_cnt <= w_stable_next;
                r_prev_raw   <= r_raw;
            end

            if (w_push) r_key_state[w_commit_idx] <= r_raw[w_commit_idx];

            if (w_drop)                r_overflow <= 1'b1;
            else if (bus.clr_overflow) r_overflow <= 1'b0;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_CODE_W)
    ) u_fifo (
        .clk     (ACLK),
        .rst     (ARESET),
        .push    (w_push),
        .wr_data (w_event),
        .pop     (w_pop),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign bus.key_valid  = !w_empty;
    assign bus.key_code   = w_head;
    assign bus.key_state  = r_key_state;
    assign bus.fifo_count = w_count;
    assign bus.overflow   = r_overflow;
    assign bus.irq        = (w_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_key_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_scan_ctrl
//  Description : Directed self-checking bench for key_scan_ctrl with a key matrix model.
//  Revision    : 1.0
// ============================================================================
module tb_key_scan_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        enable;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] pressed;
    int          n_pass  = 0;
    int          n_total = 0;

    key_scan_if #(.FIFO_DEPTH(8)) bus ();

    key_scan_ctrl #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (8)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .enable (enable),
        .col_n  (col_n),
        .row_n  (row_n),
        .bus    (bus)
    );

    always #5 ACLK = ~ACLK;

    // Key i sits at column i/4, row i%4 and pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_col(input logic want_off, input string tag);
        int n = 0;
        while (((col_n == 4'hF) != want_off) && n < 100) begin
            tick();
            n++;
        end
        n_total++;
        if ((col_n == 4'hF) != want_off) $display("FAIL %s: col_n=%h after timeout, want_off=%0b", tag, col_n, want_off);
        else n_pass++;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.key_valid && n < 300) begin
            tick();
            n++;
        end
        n_total++;
        if (!bus.key_valid) $display("FAIL %s: key_valid=0 after timeout, required 1", tag);
        else n_pass++;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        enable = 1'b0;
        pressed = 16'd0;
        bus.key_ready = 1'b0;
        bus.clr_overflow = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({col_n, bus.key_valid, bus.key_code, bus.key_state, bus.fifo_count, bus.overflow, bus.irq}
            !== {4'hF, 1'b0, 5'h00, 16'h0000, 4'd0, 1'b0, 1'b0})
            $display("FAIL reset_values: col_n=%h valid=%b code=%h state=%h count=%0d ovf=%b irq=%b",
                     col_n, bus.key_valid, bus.key_code, bus.key_state, bus.fifo_count, bus.overflow, bus.irq);
        else n_pass++;
        ARESET = 1'b0;
        tick();
        n_total++;
        if (col_n !== 4'hF) $display("FAIL idle_disabled: col_n=%h required F", col_n);
        else n_pass++;
    endtask

    task automatic test_scan_sequence();
        logic [3:0] exp_col [4];
        exp_col = '{4'hE, 4'hD, 4'hB, 4'h7};
        enable = 1'b1;
        wait_col(1'b0, "scan_start");
        for (int i = 0; i < 20; i++) begin
            n_total++;
            if (col_n !== exp_col[i/5]) $display("FAIL scan_col[%0d]: col_n=%h required %h", i, col_n, exp_col[i/5]);
            else n_pass++;
            tick();
        end
        n_total++;
        if (col_n !== 4'hF) $display("FAIL scan_eval_gap: col_n=%h required F", col_n);
        else n_pass++;
        tick();
        n_total++;
        if (col_n !== 4'hE) $display("FAIL scan_restart: col_n=%h required E", col_n);
        else n_pass++;
        n_total++;
        if ({bus.key_valid, bus.fifo_count, bus.overflow, bus.irq, bus.key_state} !== 23'd0)
            $display("FAIL scan_quiet: valid=%b count=%0d ovf=%b irq=%b state=%h required all 0",
                     bus.key_valid, bus.fifo_count, bus.overflow, bus.irq, bus.key_state);
        else n_pass++;
    endtask

    task automatic test_press_release();
        pressed = 16'h0040;
        wait_valid("press6_wait");
        n_total++;
        if ({bus.key_code, bus.key_state, bus.fifo_count, bus.irq} !== {5'h16, 16'h0040, 4'd1, 1'b1})
            $display("FAIL press6: code=%h state=%h count=%0d irq=%b required 16/0040/1/1",
                     bus.key_code, bus.key_state, bus.fifo_count, bus.irq);
        else n_pass++;
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
        n_total++;
        if ({bus.key_valid, bus.fifo_count, bus.irq} !== {1'b0, 4'd0, 1'b0})
            $display("FAIL pop6: valid=%b count=%0d irq=%b required 0/0/0", bus.key_valid, bus.fifo_count, bus.irq);
        else n_pass++;
        pressed = 16'h0000;
        wait_valid("release6_wait");
        n_total++;
        if ({bus.key_code, bus.key_state} !== {5'h06, 16'h0000})
            $display("FAIL release6: code=%h state=%h required 06/0000", bus.key_code, bus.key_state);
        else n_pass++;
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
    endtask

    task automatic test_bounce();
        int seen = 0;
        wait_col(1'b1, "bounce_align");
        pressed = 16'h0040;
        tick();
        wait_col(1'b1, "bounce_end");
        pressed = 16'h0000;
        repeat (220) begin
            tick();
            if (bus.key_valid) seen++;
        end
        n_total++;
        if ({seen != 0, bus.key_state} !== {1'b0, 16'h0000})
            $display("FAIL bounce: valid cycles=%0d state=%h required 0/0000", seen, bus.key_state);
        else n_pass++;
    endtask

    task automatic test_two_keys();
        wait_col(1'b1, "two_align");
        pressed = 16'h0208;
        wait_valid("two_wait");
        n_total++;
        if ({bus.key_code, bus.fifo_count} !== {5'h13, 4'd1})
            $display("FAIL two_first: code=%h count=%0d required 13/1", bus.key_code, bus.fifo_count);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.key_code, bus.fifo_count, bus.key_state} !== {5'h13, 4'd2, 16'h0208})
            $display("FAIL two_second: code=%h count=%0d state=%h required 13/2/0208",
                     bus.key_code, bus.fifo_count, bus.key_state);
        else n_pass++;
        bus.key_ready = 1'b1;
        tick();
        n_total++;
        if ({bus.key_code, bus.fifo_count} !== {5'h19, 4'd1})
            $display("FAIL two_pop: code=%h count=%0d required 19/1", bus.key_code, bus.fifo_count);
        else n_pass++;
        tick();
        bus.key_ready = 1'b0;
        n_total++;
        if (bus.fifo_count !== 4'd0) $display("FAIL two_drain: count=%0d required 0", bus.fifo_count);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [4:0] exp_code;
        test_reset();
        enable = 1'b1;
        pressed = 16'h01FF;
        wait_valid("ovf_wait");
        repeat (10) tick();
        n_total++;
        if ({bus.fifo_count, bus.overflow, bus.key_state, bus.key_code, bus.irq} !== {4'd8, 1'b1, 16'h01FF, 5'h10, 1'b1})
            $display("FAIL overflow: count=%0d ovf=%b state=%h code=%h irq=%b required 8/1/01FF/10/1",
                     bus.fifo_count, bus.overflow, bus.key_state, bus.key_code, bus.irq);
        else n_pass++;
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        n_total++;
        if (bus.overflow !== 1'b0) $display("FAIL clr_overflow: overflow=%b required 0", bus.overflow);
        else n_pass++;
        bus.key_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_code = 5'h10 + 5'(i);
            n_total++;
            if ({bus.key_valid, bus.key_code} !== {1'b1, exp_code})
                $display("FAIL drain[%0d]: valid=%b code=%h required 1/%h", i, bus.key_valid, bus.key_code, exp_code);
            else n_pass++;
            tick();
        end
        bus.key_ready = 1'b0;
        n_total++;
        if ({bus.key_valid, bus.key_state} !== {1'b0, 16'h01FF})
            $display("FAIL drain_end: valid=%b state=%h required 0/01FF", bus.key_valid, bus.key_state);
        else n_pass++;
    endtask

    task automatic test_reset_and_disable();
        test_reset();
        enable = 1'b1;
        pressed = 16'h0007;
        wait_valid("queue3_wait");
        repeat (3) tick();
        n_total++;
        if (bus.fifo_count !== 4'd3) $display("FAIL queue3: count=%0d required 3", bus.fifo_count);
        else n_pass++;
        wait_col(1'b0, "drive_wait");
        ARESET = 1'b1;
        #1;
        n_total++;
        if ({col_n, bus.fifo_count, bus.irq, bus.key_valid} !== {4'hF, 4'd0, 1'b0, 1'b0})
            $display("FAIL async_reset: col_n=%h count=%0d irq=%b valid=%b required F/0/0/0",
                     col_n, bus.fifo_count, bus.irq, bus.key_valid);
        else n_pass++;
        pressed = 16'h0000;
        tick();
        ARESET = 1'b0;
        wait_col(1'b0, "rescan_wait");
        tick();
        enable = 1'b0;
        tick();
        n_total++;
        if (col_n !== 4'hF) $display("FAIL disable: col_n=%h required F", col_n);
        else n_pass++;
        repeat (5) tick();
        n_total++;
        if (col_n !== 4'hF) $display("FAIL disable_hold: col_n=%h required F", col_n);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_press_release();
        test_bounce();
        test_two_keys();
        test_overflow();
        test_reset_and_disable();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
